// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module   : lsu
//  Purpose  : Load/store unit fed by the execute ALU. Runs one data-memory
//             transaction per accepted start over a req/ready handshake,
//             builds byte-lane store data/strobes, sign/zero-extends loads,
//             and flags misaligned/illegal accesses and memory timeouts.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock       in   rising-edge clock
//    reset       in   asynchronous active-low reset
//    start       in   one-cycle request, sampled only while idle
//    mem_rw      in   0 = load, 1 = store
//    funct3      in   access size/sign (B/H/W/BU/HU)
//    alu_res     in   effective byte address
//    rs2         in   store source data
//    busy        out  high while a transaction is in flight
//    done        out  one-cycle completion pulse
//    load_data   out  extended load result, held until the next load
//    misaligned  out  alignment / illegal-funct3 error pulse (with done)
//    timeout     out  memory timeout pulse (with done)
//    dmem_req    out  memory request, held until dmem_ready
//    dmem_we     out  memory write enable
//    dmem_addr   out  word-aligned memory address
//    dmem_wstrb  out  byte write enables
//    dmem_wdata  out  lane-replicated store data
//    dmem_ready  in   memory accept/complete
//    dmem_rdata  in   memory read word, valid with dmem_ready
// ============================================================================
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        mem_rw,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_res,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        timeout,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]       state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mis_q, mis_d;        // ERR cause: 1 = misaligned, 0 = timeout
  logic [31:0]      load_data_q, load_data_d;

  logic             illegal;
  logic [31:0]      lane_wdata;
  logic [3:0]       lane_wstrb;
  logic [31:0]      rd_shift;
  logic [31:0]      rd_ext;

  // --------------------------------------------------------------------------
  // Access legality, evaluated on the raw inputs in the start cycle.
  // funct3[1:0]==01 covers both H and HU.
  // --------------------------------------------------------------------------
  always_comb begin
    illegal = 1'b0;
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
      illegal = 1'b1;
    if (mem_rw && funct3[2])
      illegal = 1'b1;
    if (funct3[1:0] == 2'b01 && alu_res[0])
      illegal = 1'b1;
    if (funct3 == F3_W && alu_res[1:0] != 2'b00)
      illegal = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Store lane construction. Loads never strobe any byte.
  // --------------------------------------------------------------------------
  always_comb begin
    lane_wdata = rs2;
    lane_wstrb = 4'b0000;
    case (funct3[1:0])
      2'b00: begin
        lane_wdata = {4{rs2[7:0]}};
        lane_wstrb = 4'b0001 << alu_res[1:0];
      end
      2'b01: begin
        lane_wdata = {2{rs2[15:0]}};
        lane_wstrb = 4'b0011 << alu_res[1:0];
      end
      default: begin
        lane_wdata = rs2;
        lane_wstrb = 4'b1111;
      end
    endcase
    if (!mem_rw)
      lane_wstrb = 4'b0000;
  end

  // --------------------------------------------------------------------------
  // Load extraction from the returned word using the latched byte offset.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_shift = dmem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      F3_B:    rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      F3_BU:   rd_ext = {24'h000000, rd_shift[7:0]};
      F3_H:    rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      F3_HU:   rd_ext = {16'h0000, rd_shift[15:0]};
      default: rd_ext = dmem_rdata;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start)
          state_d = illegal ? ST_ERR : ST_REQ;
      end
      ST_REQ: begin
        // A ready in the last allowed cycle still wins over the timeout.
        if (dmem_ready)
          state_d = ST_DONE;
        else if (cnt_q == CNT_LAST)
          state_d = ST_ERR;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE) || (state_q == ST_ERR);
    misaligned = (state_q == ST_ERR) && mis_q;
    timeout    = (state_q == ST_ERR) && !mis_q;
    dmem_req   = (state_q == ST_REQ);
    dmem_we    = (state_q == ST_REQ) && we_q;
    dmem_wstrb = (state_q == ST_REQ) ? wstrb_q : 4'b0000;
    dmem_addr  = {addr_q[31:2], 2'b00};
    dmem_wdata = wdata_q;
    load_data  = load_data_q;
  end

  // --------------------------------------------------------------------------
  // Datapath next-state: request capture, wait counter, load result.
  // --------------------------------------------------------------------------
  always_comb begin
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    cnt_d       = cnt_q;
    mis_d       = mis_q;
    load_data_d = load_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          we_d     = mem_rw;
          funct3_d = funct3;
          addr_d   = alu_res;
          wdata_d  = lane_wdata;
          wstrb_d  = lane_wstrb;
          cnt_d    = '0;
          mis_d    = illegal;
        end
      end
      ST_REQ: begin
        if (dmem_ready) begin
          if (!we_q)
            load_data_d = rd_ext;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          mis_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'b0000;
      cnt_q       <= '0;
      mis_q       <= 1'b0;
      load_data_q <= 32'h0;
    end else begin
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      cnt_q       <= cnt_d;
      mis_q       <= mis_d;
      load_data_q <= load_data_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the execute ALU: it takes the ALU result as the effective address, together with rs2 as store data, and runs one data-memory transaction over a req/ready handshake. For stores it produces byte-lane write data and strobes; for loads it returns a sign- or zero-extended value for writeback. While a transaction is in flight it holds `busy` high to stall the pipeline, and it reports misaligned/illegal accesses and memory timeouts.

## Interface
- `TIMEOUT_CYCLES`, 16: maximum cycles `dmem_req` is held without `dmem_ready` before aborting; must be ≥1.
- `clock  in  1`: single clock; all state updates on rising edge.
- `reset  in  1`: asynchronous, active-low.
- `start  in  1`: one-cycle request from execute; sampled only in IDLE.
- `mem_rw  in  1`: 0 = load, 1 = store.
- `funct3  in  3`: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- `alu_res  in  32`: effective byte address.
- `rs2  in  32`: store source data.
- `busy  out  1`: high whenever state ≠ IDLE.
- `done  out  1`: one-cycle completion pulse.
- `load_data  out  32`: extended load result; valid from `done`, held until the next load completes.
- `misaligned  out  1`: one-cycle pulse, coincident with `done`, for alignment or illegal-funct3 errors.
- `timeout  out  1`: one-cycle pulse, coincident with `done`, when the memory never answers.
- `dmem_req  out  1`: memory request, held until accepted.
- `dmem_we  out  1`: 1 = write.
- `dmem_addr  out  32`: word-aligned address, {addr[31:2],2'b00}.
- `dmem_wstrb  out  4`: byte write enables; 0000 for loads.
- `dmem_wdata  out  32`: lane-replicated store data.
- `dmem_ready  in  1`: memory accept/complete, sampled at the rising edge.
- `dmem_rdata  in  32`: read word, valid in the cycle `dmem_ready` is high.

## Operation
- States: IDLE, REQ, DONE, ERR.
- **IDLE:**
  - On `start`, latch `mem_rw`, `funct3`, `alu_res` and `rs2`.
  - Check the access. Illegal: H/HU with addr[0]=1; W with addr[1:0]≠00; funct3 ∈ {011,110,111}; store with funct3[2]=1.
  - Illegal → ERR with `misaligned` set. Otherwise → REQ with wait counter = 0.
- **REQ:**
  - `dmem_req`=1; `dmem_addr`, `dmem_we`, `dmem_wstrb` and `dmem_wdata` are driven from latched registers and stay stable.
  - If `dmem_ready`=1: loads latch the extracted read data → DONE.
  - Else if counter = `TIMEOUT_CYCLES`-1 → ERR with `timeout` set. Else counter +1.
- **DONE:** `done`=1 for one cycle → IDLE.
- **ERR:** `done`=1 plus exactly one of `misaligned`/`timeout` for one cycle → IDLE. No memory request is ever issued for a misaligned access.
- **Store lanes** (o = addr[1:0]):
  - B: wdata = {4{rs2[7:0]}}, wstrb = 0001<<o.
  - H: wdata = {2{rs2[15:0]}}, wstrb = 0011<<o.
  - W: wdata = rs2, wstrb = 1111.
- **Load extraction:**
  - s = rdata >> (8·o).
  - B: sign-extend s[7:0]. BU: zero-extend s[7:0].
  - H: sign-extend s[15:0]. HU: zero-extend s[15:0].
  - W: rdata.
- **Register behaviour:**
  - Stores, and errors, leave `load_data` unchanged.
  - `start` while `busy` is ignored and does not queue.
  - Inputs may change after the `start` cycle; only the latched copies are used.

## Timing
- **Reset:** state IDLE, counter 0, and all outputs 0, including `load_data`. Reset asserted mid-transaction drops `dmem_req` immediately (asynchronous) and discards the transaction, with no `done`.
- **Latency:**
  - `start` at edge N → `dmem_req` high in cycle N+1.
  - `dmem_ready` high at edge N+1+k → `done` in cycle N+2+k.
  - Minimum `start`→`done` is 2 cycles.
- **Misaligned:** `start` at edge N → `done`+`misaligned` in cycle N+1.
- **Timeout:** `dmem_req` high for exactly `TIMEOUT_CYCLES` cycles, then `done`+`timeout` in the following cycle. If `dmem_ready` rises in the final allowed cycle, it completes normally.
- **Back-to-back:** `start` may be asserted in the DONE/ERR cycle but is ignored. The next accepted `start` is in the first IDLE cycle, so the minimum issue interval is 3 cycles.
- **`busy`:** high from the cycle after the `start` edge through the DONE/ERR cycle inclusive.

## Test plan
- SW rs2=0xDEADBEEF, addr=0x100, ready on the first REQ cycle → dmem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF, we=1; `done` 2 cycles after `start`.
- SB rs2=0x000000A5, addr=0x203 → dmem_addr=0x200, wstrb=1000, wdata=0xA5A5A5A5.
- LB / LBU / LH / LHU, addr=0x302, rdata=0x80F0_1234 → load_data = 0xFFFFFFF0 / 0x000000F0 / 0xFFFF80F0 / 0x000080F0.
- LW addr=0x101 → `done`+`misaligned` 1 cycle after `start`; `dmem_req` never asserted; `load_data` unchanged.
- LW with `dmem_ready` held low, TIMEOUT_CYCLES=16 → `dmem_req` high for 16 cycles, then `done`+`timeout`. Repeat with ready in the 16th cycle → normal completion.
- Reset pulsed low during REQ → `dmem_req` and `busy` drop immediately. A `start` pulsed during a busy transaction is ignored, and exactly one `done` is produced.
